// File: rtl/net_pkg.sv
// Shared types and helpers for the NIC transmit path: default beat width,
// the {last, data} beat record and the round-robin pick used by arbiters.
package net_pkg;

  localparam int NET_DATA_W = 64;

  typedef struct packed {
    logic                  last;
    logic [NET_DATA_W-1:0] data;
  } net_beat_t;

  // First set bit of req scanning ptr+1, ptr+2, ... modulo n (n <= 16).
  // Returns 0 when nothing is requested; callers only use it when |req.
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  n);
    logic [3:0] pick;
    logic       found;
    logic [4:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= int'(n)) begin
        idx = 5'((int'(ptr) + i) % int'(n));
        if (!found && req[idx[3:0]]) begin
          pick  = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/net_tx_packet_arbiter_if.sv
// Source-side and network-side beat streams of the transmit arbiter.
// Handshake: a beat transfers on a rising edge where valid && ready; a source holds
// data/last stable while valid && !ready, and ready never depends on valid.
interface net_tx_packet_arbiter_if #(
  parameter int N_PORTS = 2,
  parameter int DATA_W  = 64
);
  logic [N_PORTS-1:0]        in_valid;
  logic [N_PORTS-1:0]        in_ready;
  logic [N_PORTS*DATA_W-1:0] in_data;
  logic [N_PORTS-1:0]        in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;

  // Sources and network sink together.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The arbiter.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/net_beat_fifo2.sv
// Two-entry registered FIFO of {last, data} beats; outputs come straight from the
// head entry so they stay stable under backpressure.
module net_beat_fifo2 #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        count
);

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t mem [2];
  logic  rd_ptr;
  logic  wr_ptr;
  logic  pop_en;

  assign pop_en    = (count != 2'd0) && pop;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr].data;
  assign out_last  = mem[rd_ptr].last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{last: push_last, data: push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_en) rd_ptr <= ~rd_ptr;
      case ({push, pop_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/net_tx_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing the NIC transmit stream between
// N_PORTS sources; a grant is held until the owner's last beat is accepted.
module net_tx_packet_arbiter
  import net_pkg::*;
#(
  parameter int  N_PORTS = 2,
  parameter int  DATA_W  = NET_DATA_W,
  localparam int GRANT_W = $clog2(N_PORTS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  net_tx_packet_arbiter_if.slave bus,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         state;
  logic [GRANT_W-1:0] rr_ptr;
  logic [GRANT_W-1:0] pick;
  logic [1:0]         fifo_count;
  logic [N_PORTS-1:0] in_ready;
  logic               push;
  logic [DATA_W-1:0]  push_data;
  logic               push_last;
  logic               fifo_valid;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_last;

  // Ready is built from state, grant and fill level only, never from in_valid.
  always_comb begin
    in_ready = '0;
    if (state == ST_BUSY && fifo_count != 2'd2) in_ready[grant_id] = 1'b1;
  end

  assign push      = |(bus.in_valid & in_ready);
  assign push_data = bus.in_data[int'(grant_id)*DATA_W +: DATA_W];
  assign push_last = bus.in_last[grant_id];
  assign pick      = GRANT_W'(rr_pick(16'(bus.in_valid), 4'(rr_ptr), 5'(N_PORTS)));
  assign busy      = (state == ST_BUSY);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= GRANT_W'(N_PORTS - 1);
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.in_valid) begin
            grant_id <= pick;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (push && push_last) begin
            rr_ptr <= grant_id;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  net_beat_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .pop       (bus.out_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .out_last  (fifo_last),
    .count     (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_data;
  assign bus.out_last  = fifo_last;

endmodule

// File: tb/tb_net_tx_packet_arbiter.sv
// Directed bench for net_tx_packet_arbiter with three sources: reset, single source,
// contention order, backpressure, mid-packet stall and async reset mid-packet.
module tb_net_tx_packet_arbiter;
  localparam int NP = 3;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  net_tx_packet_arbiter_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();
  logic [1:0] grant_id;
  logic       busy;

  net_tx_packet_arbiter #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // ---------------- bench state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int model_count = 0;
  int sent [NP];
  logic [NP-1:0] en = '0;
  logic [DW:0]   src_q [NP][$];
  logic [DW:0]   got_q [$];
  int            got_cyc [$];
  logic [DW:0]   exp_q [$];
  logic [NP-1:0] fire_in;
  logic          fire_out;
  logic [DW:0]   out_beat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- source driver + output monitor ----------------
  initial begin
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_last  = '0;
    for (int p = 0; p < NP; p++) sent[p] = 0;
    forever begin
      @(negedge clock);
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      out_beat = {bus.out_last, bus.out_data};
      @(posedge clock);
      cyc++;
      if (reset_n) begin
        for (int p = 0; p < NP; p++) begin
          if (fire_in[p] && src_q[p].size() > 0) begin
            void'(src_q[p].pop_front());
            sent[p]++;
          end
        end
        if (fire_out) begin
          got_q.push_back(out_beat);
          got_cyc.push_back(cyc);
        end
        model_count = model_count + ((|fire_in) ? 1 : 0) - (fire_out ? 1 : 0);
      end
      #2;
      for (int p = 0; p < NP; p++) begin
        bus.in_valid[p] = en[p] && (src_q[p].size() > 0);
        bus.in_data[p*DW +: DW] = (src_q[p].size() > 0) ? src_q[p][0][DW-1:0] : '0;
        bus.in_last[p] = (src_q[p].size() > 0) ? src_q[p][0][DW] : 1'b0;
      end
    end
  end

  task automatic clear_bench();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      sent[p] = 0;
    end
    en = '0;
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    model_count = 0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    bus.out_ready = 1'b0;
    clear_bench();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;

    // 1: reset held with every source requesting
    bus.out_ready = 1'b0;
    reset_n = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].push_back({1'b1, 16'(p)});
    en = '1;
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("t1_first_grant", 64'(grant_id), 64'(0));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_in_ready", 64'(bus.in_ready), 64'(3'b001));
    for (int i = 0; i < 40 && got_q.size() < 3; i++) tick();
    for (int p = 0; p < NP; p++) exp_q.push_back({1'b1, 16'(p)});
    check_got("t1_order");

    // 2: port 1 alone, 4 beats 0x11..0x14
    reset_dut();
    for (int b = 0; b < 4; b++) src_q[1].push_back({b == 3, 16'(16'h11 + b)});
    en[1] = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("t2_grant", 64'(grant_id), 64'(1));
    check("t2_busy", 64'(busy), 64'(1));
    check("t2_in_ready", 64'(bus.in_ready), 64'(3'b010));
    check("t2_no_out_yet", 64'(bus.out_valid), 64'(0));
    for (int b = 0; b < 4; b++) begin
      tick();
      check("t2_out_valid", 64'(bus.out_valid), 64'(1));
      check("t2_out_data", 64'(bus.out_data), 64'(16'h11 + b));
      check("t2_out_last", 64'(bus.out_last), 64'(b == 3));
      check("t2_busy_beat", 64'(busy), 64'(b != 3));
    end
    check("t2_in_ready_idle", 64'(bus.in_ready), 64'(0));
    tick();
    check("t2_drained", 64'(bus.out_valid), 64'(0));

    // 3: all ports offer two 2-beat packets each
    reset_dut();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 2; b++)
          src_q[p].push_back({b == 1, 16'(16'h3000 | (p << 8) | (k << 4) | b)});
    en = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 12; i++) tick();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++)
        for (int b = 0; b < 2; b++)
          exp_q.push_back({b == 1, 16'(16'h3000 | (p << 8) | (k << 4) | b)});
    check_got("t3_order");
    for (int i = 1; i < got_cyc.size(); i++)
      check("t3_gap", 64'(got_cyc[i] - got_cyc[i-1]), 64'((i % 2 == 0) ? 2 : 1));

    // 4: backpressure, port 0 sends 0xA0..0xA7
    reset_dut();
    for (int b = 0; b < 8; b++) src_q[0].push_back({b == 7, 16'(16'hA0 + b)});
    en[0] = 1'b1;
    for (int i = 0; i < 300 && got_q.size() < 8; i++) begin
      bus.out_ready = (i < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (model_count == 2) check("t4_ready_full", 64'(bus.in_ready[0]), 64'(0));
    end
    bus.out_ready = 1'b1;
    repeat (5) tick();
    for (int b = 0; b < 8; b++) exp_q.push_back({b == 7, 16'(16'hA0 + b)});
    check_got("t4_beats");

    // 5: port 0 stalls mid-packet while port 1 requests
    reset_dut();
    for (int b = 0; b < 4; b++) src_q[0].push_back({b == 3, 16'(16'h50 + b)});
    for (int b = 0; b < 2; b++) src_q[1].push_back({b == 1, 16'(16'h60 + b)});
    en = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && sent[0] < 2; i++) tick();
    check("t5_two_sent", 64'(sent[0]), 64'(2));
    en[0] = 1'b0;
    repeat (3) begin
      tick();
      check("t5_stall_grant", 64'(grant_id), 64'(0));
      check("t5_stall_busy", 64'(busy), 64'(1));
    end
    en[0] = 1'b1;
    for (int i = 0; i < 50 && got_q.size() < 6; i++) tick();
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, 16'(16'h50 + b)});
    for (int b = 0; b < 2; b++) exp_q.push_back({b == 1, 16'(16'h60 + b)});
    check_got("t5_order");
    check("t5_next_grant", 64'(grant_id), 64'(1));

    // 6: async reset while beat 3 of 5 is offered
    reset_dut();
    for (int b = 0; b < 5; b++) src_q[0].push_back({b == 4, 16'(16'h70 + b)});
    en[0] = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && sent[0] < 2; i++) tick();
    check("t6_two_sent", 64'(sent[0]), 64'(2));
    #3;
    reset_n = 1'b0;
    clear_bench();
    #1;
    check("t6_out_valid", 64'(bus.out_valid), 64'(0));
    check("t6_in_ready", 64'(bus.in_ready), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_grant", 64'(grant_id), 64'(0));
    d = bus.out_data;
    check("t6_out_data", 64'(d), 64'(0));
    check("t6_out_last", 64'(bus.out_last), 64'(0));
    tick();
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("t6_no_residual", 64'(got_q.size()), 64'(0));
    check("t6_idle_out", 64'(bus.out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of sequence, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
